// File: rtl/register_file_pipe.sv
// -----------------------------------------------------------------------------
// register_file_pipe
//
// Register file with two registered read ports, one byte-masked write port and
// a per-register busy scoreboard. A write and a scoreboard set that land in the
// same cycle as a read are visible to that read. The read returns the state the
// register file holds after the current edge.
//
// Parameters
//   DATA_W   : register width in bits (multiple of 8)
//   ADDR_W   : register index width, depth = 2**ADDR_W
//   ZERO_REG : 1 -> register 0 always reads zero and is never busy
//
// Ports
//   clk                    : clock, all state changes on the rising edge
//   rst_n                  : synchronous active-low reset
//   readReg1/readReg2      : read indices, captured when readEn=1
//   readEn                 : read request
//   readData1/readData2    : registered read data (one cycle after readEn)
//   readBusy1/readBusy2    : registered scoreboard bit of the captured index
//   readValid              : readData*/readBusy* were produced by last cycle's readEn
//   writeReg/writeData     : write index and data
//   write                  : write strobe, also clears busy[writeReg]
//   writeByteEn            : per-byte write mask
//   busySet/busyReg        : mark busyReg as having a pending producer
// -----------------------------------------------------------------------------
module register_file_pipe #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_W-1:0]     readReg1,
    input  logic [ADDR_W-1:0]     readReg2,
    input  logic                  readEn,
    output logic [DATA_W-1:0]     readData1,
    output logic [DATA_W-1:0]     readData2,
    output logic                  readBusy1,
    output logic                  readBusy2,
    output logic                  readValid,
    input  logic [ADDR_W-1:0]     writeReg,
    input  logic [DATA_W-1:0]     writeData,
    input  logic                  write,
    input  logic [DATA_W/8-1:0]   writeByteEn,
    input  logic                  busySet,
    input  logic [ADDR_W-1:0]     busyReg
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int BYTES = DATA_W / 8;

    // Architectural state. Every register must clear on reset, so the array is
    // kept in flops rather than a RAM macro.
    logic [DATA_W-1:0] regs_reg  [DEPTH];
    logic [DATA_W-1:0] regs_next [DEPTH];
    logic [DEPTH-1:0]  busy_reg;
    logic [DEPTH-1:0]  busy_next;

    // Registered read port state
    logic [DATA_W-1:0] read_data1_reg;
    logic [DATA_W-1:0] read_data2_reg;
    logic              read_busy1_reg;
    logic              read_busy2_reg;
    logic              read_valid_reg;

    // Expand the byte enables into a bit mask once; it is shared by all
    // registers since only the addressed one uses it.
    logic [DATA_W-1:0] write_mask;

    genvar gi;
    generate
        for (gi = 0; gi < BYTES; gi++) begin : g_mask
            assign write_mask[gi*8 +: 8] = {8{writeByteEn[gi]}};
        end
    endgenerate

    // Next-state of the whole file. Busy clear from a write is applied first so
    // that a same-cycle set on the same index overrides it (set wins).
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            regs_next[i] = regs_reg[i];
            busy_next[i] = busy_reg[i];
            if (write && (writeReg == ADDR_W'(i))) begin
                regs_next[i] = (regs_reg[i] & ~write_mask) | (writeData & write_mask);
                busy_next[i] = 1'b0;
            end
            if (busySet && (busyReg == ADDR_W'(i))) begin
                busy_next[i] = 1'b1;
            end
        end
        if (ZERO_REG != 0) begin
            regs_next[0] = '0;
            busy_next[0] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_reg[i] <= '0;
            end
            busy_reg <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_reg[i] <= regs_next[i];
            end
            busy_reg <= busy_next;
        end
    end

    // Reads sample the next-state view, which gives write-first data bypass
    // (byte merged), busy clear on write and busy set bypass in one mux, and
    // makes both ports agree whenever their indices match.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            read_data1_reg <= '0;
            read_data2_reg <= '0;
            read_busy1_reg <= 1'b0;
            read_busy2_reg <= 1'b0;
            read_valid_reg <= 1'b0;
        end else begin
            read_valid_reg <= readEn;
            if (readEn) begin
                read_data1_reg <= regs_next[readReg1];
                read_data2_reg <= regs_next[readReg2];
                read_busy1_reg <= busy_next[readReg1];
                read_busy2_reg <= busy_next[readReg2];
            end
        end
    end

    assign readData1 = read_data1_reg;
    assign readData2 = read_data2_reg;
    assign readBusy1 = read_busy1_reg;
    assign readBusy2 = read_busy2_reg;
    assign readValid = read_valid_reg;

endmodule

// File: tb/tb_register_file_pipe.sv
// -----------------------------------------------------------------------------
// tb_register_file_pipe
//
// Drives register_file_pipe (default parameters) with directed scenarios and
// randomized traffic. A behavioural model tracks register contents and busy
// bits; a read returns the file state as it stands after the edge that
// captured it. Every cycle the DUT outputs are compared to the model, and the
// directed scenarios also compare against hand-computed literals.
// -----------------------------------------------------------------------------
module tb_register_file_pipe;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] readReg1, readReg2;
    logic          readEn;
    logic [DW-1:0] readData1, readData2;
    logic          readBusy1, readBusy2;
    logic          readValid;
    logic [AW-1:0] writeReg;
    logic [DW-1:0] writeData;
    logic          write;
    logic [3:0]    writeByteEn;
    logic          busySet;
    logic [AW-1:0] busyReg;

    always #5 clk = ~clk;

    register_file_pipe #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .readReg1   (readReg1),
        .readReg2   (readReg2),
        .readEn     (readEn),
        .readData1  (readData1),
        .readData2  (readData2),
        .readBusy1  (readBusy1),
        .readBusy2  (readBusy2),
        .readValid  (readValid),
        .writeReg   (writeReg),
        .writeData  (writeData),
        .write      (write),
        .writeByteEn(writeByteEn),
        .busySet    (busySet),
        .busyReg    (busyReg)
    );

    int total_cnt = 0;
    int pass_cnt  = 0;
    int cyc       = 0;

    // Behavioural model
    logic [DW-1:0] m_regs [DEPTH];
    logic          m_busy [DEPTH];
    logic          m_valid;
    logic [DW-1:0] m_d1, m_d2;
    logic          m_b1, m_b2;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        total_cnt++;
        if (act === req) pass_cnt++;
        else $display("FAIL %s (cycle %0d): got %h, required %h", name, cyc, act, req);
    endtask

    // Apply the rules for one rising edge to the model using the current inputs.
    task automatic model_edge();
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                m_regs[i] = '0;
                m_busy[i] = 1'b0;
            end
            m_valid = 1'b0;
            m_d1 = '0; m_d2 = '0; m_b1 = 1'b0; m_b2 = 1'b0;
        end else begin
            if (write && writeReg != 0) begin
                for (int b = 0; b < 4; b++)
                    if (writeByteEn[b]) m_regs[writeReg][8*b +: 8] = writeData[8*b +: 8];
            end
            if (write) m_busy[writeReg] = 1'b0;
            if (busySet && busyReg != 0) m_busy[busyReg] = 1'b1;
            m_valid = readEn;
            if (readEn) begin
                m_d1 = m_regs[readReg1];
                m_d2 = m_regs[readReg2];
                m_b1 = m_busy[readReg1];
                m_b2 = m_busy[readReg2];
            end
        end
    endtask

    // One clock cycle: drive inputs, let the edge happen, then compare every
    // output against the model half a period later.
    task automatic cycle(input logic rn, input logic we, input logic [AW-1:0] wr,
                         input logic [DW-1:0] wd, input logic [3:0] be,
                         input logic bs, input logic [AW-1:0] br,
                         input logic re, input logic [AW-1:0] r1, input logic [AW-1:0] r2);
        rst_n = rn; write = we; writeReg = wr; writeData = wd; writeByteEn = be;
        busySet = bs; busyReg = br; readEn = re; readReg1 = r1; readReg2 = r2;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        cyc++;
        check("readValid", {31'b0, readValid}, {31'b0, m_valid});
        check("readData1", readData1, m_d1);
        check("readData2", readData2, m_d2);
        check("readBusy1", {31'b0, readBusy1}, {31'b0, m_b1});
        check("readBusy2", {31'b0, readBusy2}, {31'b0, m_b2});
    endtask

    task automatic idle();
        cycle(1'b1, 1'b0, '0, '0, 4'h0, 1'b0, '0, 1'b0, '0, '0);
    endtask
    task automatic wr_op(input logic [AW-1:0] idx, input logic [DW-1:0] d, input logic [3:0] be);
        cycle(1'b1, 1'b1, idx, d, be, 1'b0, '0, 1'b0, '0, '0);
    endtask
    task automatic rd_op(input logic [AW-1:0] a, input logic [AW-1:0] b);
        cycle(1'b1, 1'b0, '0, '0, 4'h0, 1'b0, '0, 1'b1, a, b);
    endtask
    task automatic set_op(input logic [AW-1:0] idx);
        cycle(1'b1, 1'b0, '0, '0, 4'h0, 1'b1, idx, 1'b0, '0, '0);
    endtask

    function automatic logic [AW-1:0] pick_idx();
        if ($urandom_range(0, 1) == 0) return AW'($urandom_range(0, 3));
        return AW'($urandom_range(0, DEPTH - 1));
    endfunction

    initial begin
        // Reset and reset state
        cycle(1'b0, 1'b0, '0, '0, 4'h0, 1'b0, '0, 1'b0, '0, '0);
        cycle(1'b0, 1'b1, 5'd4, 32'h1234_5678, 4'hF, 1'b1, 5'd4, 1'b1, 5'd4, 5'd4);
        check("reset_valid", {31'b0, readValid}, 32'd0);
        check("reset_data1", readData1, 32'd0);

        // Basic write then read
        wr_op(5'd5, 32'hDEAD_BEEF, 4'hF);
        check("wr_only_valid", {31'b0, readValid}, 32'd0);
        rd_op(5'd5, 5'd4);
        check("basic_data1", readData1, 32'hDEAD_BEEF);
        check("basic_model", m_d1, 32'hDEAD_BEEF);
        check("basic_valid", {31'b0, readValid}, 32'd1);
        check("reg4_untouched", readData2, 32'd0);
        idle();
        check("hold_valid", {31'b0, readValid}, 32'd0);
        check("hold_data1", readData1, 32'hDEAD_BEEF);

        // Byte mask
        wr_op(5'd7, 32'h1122_3344, 4'hF);
        wr_op(5'd7, 32'hAABB_CCDD, 4'b0101);
        rd_op(5'd7, 5'd7);
        check("bytemask_data1", readData1, 32'h11BB_33DD);
        check("bytemask_model", m_d1, 32'h11BB_33DD);

        // Write-first bypass on both ports, busy cleared by the write
        set_op(5'd3);
        cycle(1'b1, 1'b1, 5'd3, 32'h5A5A_5A5A, 4'hF, 1'b0, '0, 1'b1, 5'd3, 5'd3);
        check("bypass_data1", readData1, 32'h5A5A_5A5A);
        check("bypass_data2", readData2, 32'h5A5A_5A5A);
        check("bypass_busy1", {31'b0, readBusy1}, 32'd0);
        check("bypass_busy2", {31'b0, readBusy2}, 32'd0);
        // Byte-masked bypass
        cycle(1'b1, 1'b1, 5'd3, 32'h0000_00FF, 4'b0001, 1'b0, '0, 1'b1, 5'd3, 5'd2);
        check("bypass_mask", readData1, 32'h5A5A_5AFF);

        // Scoreboard
        set_op(5'd9);
        rd_op(5'd9, 5'd8);
        check("sb_set_busy1", {31'b0, readBusy1}, 32'd1);
        check("sb_other_busy2", {31'b0, readBusy2}, 32'd0);
        cycle(1'b1, 1'b1, 5'd9, 32'h0000_0099, 4'hF, 1'b1, 5'd9, 1'b0, '0, '0);
        rd_op(5'd9, 5'd9);
        check("sb_setwins_busy", {31'b0, readBusy1}, 32'd1);
        check("sb_setwins_data", readData1, 32'h0000_0099);
        wr_op(5'd9, 32'h0000_0100, 4'h0);
        rd_op(5'd9, 5'd9);
        check("sb_clear_busy", {31'b0, readBusy1}, 32'd0);
        check("sb_clear_data", readData1, 32'h0000_0099);
        // Set bypass: same-cycle set and read
        cycle(1'b1, 1'b0, '0, '0, 4'h0, 1'b1, 5'd10, 1'b1, 5'd10, 5'd10);
        check("sb_set_bypass", {31'b0, readBusy2}, 32'd1);

        // Zero register
        cycle(1'b1, 1'b1, 5'd0, 32'hFFFF_FFFF, 4'hF, 1'b1, 5'd0, 1'b1, 5'd0, 5'd0);
        check("zero_bypass_data", readData1, 32'd0);
        check("zero_bypass_busy", {31'b0, readBusy1}, 32'd0);
        rd_op(5'd0, 5'd31);
        check("zero_data", readData1, 32'd0);
        check("zero_busy", {31'b0, readBusy1}, 32'd0);

        // Randomized traffic with occasional resets
        for (int n = 0; n < 500; n++) begin
            logic          rn, we, bs, re;
            logic [AW-1:0] wr, br, r1, r2;
            rn = ($urandom_range(0, 59) != 0);
            we = ($urandom_range(0, 2) != 0);
            bs = ($urandom_range(0, 3) == 0);
            re = ($urandom_range(0, 3) != 0);
            wr = pick_idx(); br = pick_idx(); r1 = pick_idx();
            r2 = ($urandom_range(0, 3) == 0) ? r1 : pick_idx();
            cycle(rn, we, wr, $urandom, 4'($urandom_range(0, 15)), bs, br, re, r1, r2);
        end

        // Reset mid-operation
        wr_op(5'd1, 32'hCAFE_0001, 4'hF);
        wr_op(5'd2, 32'hCAFE_0002, 4'hF);
        set_op(5'd2);
        set_op(5'd30);
        rd_op(5'd2, 5'd1);
        check("pre_reset_data1", readData1, 32'hCAFE_0002);
        check("pre_reset_busy1", {31'b0, readBusy1}, 32'd1);
        cycle(1'b0, 1'b1, 5'd6, 32'h7777_7777, 4'hF, 1'b1, 5'd6, 1'b1, 5'd2, 5'd1);
        check("rst_mid_valid", {31'b0, readValid}, 32'd0);
        check("rst_mid_data1", readData1, 32'd0);
        for (int i = 0; i < DEPTH; i++) begin
            rd_op(AW'(i), AW'(DEPTH - 1 - i));
            check("post_reset_data", readData1, 32'd0);
            check("post_reset_busy", {31'b0, readBusy1}, 32'd0);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
